// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: groups the sequencer's control inputs and phase-pulse outputs.
// Latency: none (wires only). Backpressure: none; the consumer must take every pulse as issued.
// master drives run/halt/step/done/seqtype and observes the pulses; slave is the sequencer side.
interface instr_sequencer_if #(
  parameter int NPHASE = 6
);
  // control towards the sequencer
  logic              run;        // rising edge starts continuous execution
  logic              halt;       // level; stop at next instruction boundary
  logic              step;       // rising edge executes a single instruction
  logic              done;       // early end of execute phases from handlers
  logic [1:0]        seqtype;    // {ppind, ind} addressing class

  // phase pulses from the sequencer
  logic              ck_fetch;
  logic              stb_fetch;
  logic              ck_auto1;
  logic              stb_auto1;
  logic              ck_auto2;
  logic              stb_auto2;
  logic              ck_ind;
  logic              stb_ind;
  logic [NPHASE-1:0] ck;         // bit k -> execute phase k+1 setup
  logic [NPHASE-1:0] stb;        // bit k -> execute phase k+1 strobe
  logic              running;
  logic [3:0]        phase;      // 1..NPHASE in execute phases, else 0
  logic              instr_end;

  modport master (
    output run, halt, step, done, seqtype,
    input  ck_fetch, stb_fetch, ck_auto1, stb_auto1, ck_auto2, stb_auto2,
           ck_ind, stb_ind, ck, stb, running, phase, instr_end
  );

  modport slave (
    input  run, halt, step, done, seqtype,
    output ck_fetch, stb_fetch, ck_auto1, stb_auto1, ck_auto2, stb_auto2,
           ck_ind, stb_ind, ck, stb, running, phase, instr_end
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction phase sequencer (fetch, auto-index, indirect, NPHASE execute phases).
// Latency: start edge in IDLE -> CK_FETCH next cycle; every phase lasts 2 cycles (CK then STB).
// Backpressure: none; DONE shortens execution, HALT stops only at an instruction boundary.
//
// Ports: i_clk (rising edge), i_rst (async active-high), io_seq (instr_sequencer_if.slave):
//   inputs run/halt/step/done/seqtype, outputs ck_*/stb_* pulses, ck/stb[NPHASE], running,
//   phase, instr_end.
// Optional feature: define SEQ_SINGLE_STEP_EN to enable the STEP input; without it STEP is
//   present on the interface but ignored.
module instr_sequencer #(
  parameter int NPHASE = 6   // legal range 1..15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  instr_sequencer_if.slave  io_seq
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_AUTO1 = 3'd2;
  localparam logic [2:0] ST_AUTO2 = 3'd3;
  localparam logic [2:0] ST_IND   = 3'd4;
  localparam logic [2:0] ST_EXEC  = 3'd5;

  localparam logic [3:0] LP_LAST_PHASE = 4'(NPHASE);

  // state is (r_state, r_phase, r_stb): r_stb=0 is the CK cycle, r_stb=1 the STB cycle
  logic [2:0] r_state;
  logic [3:0] r_phase;
  logic       r_stb;
  logic [2:0] w_state_nxt;
  logic [3:0] w_phase_nxt;
  logic       w_stb_nxt;

  logic       r_run_q;
  logic       r_done;
  logic       r_halt_pend;
  logic       r_instr_end;

  logic       w_run_edge;
  logic       w_step_edge;
  logic       w_step_mode;
  logic       w_start;
  logic       w_end;
  logic       w_stop;

  assign w_run_edge = io_seq.run & ~r_run_q;

`ifdef SEQ_SINGLE_STEP_EN
  logic r_step_q;
  logic r_step_mode;

  assign w_step_edge = io_seq.step & ~r_step_q;
  assign w_step_mode = r_step_mode;

  // a step edge (alone or together with a run edge) that starts an instruction
  // arms single-step mode until the sequencer returns to IDLE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_step_q    <= io_seq.step;
      r_step_mode <= 1'b0;
    end else begin
      r_step_q <= io_seq.step;
      if (w_state_nxt == ST_IDLE)
        r_step_mode <= 1'b0;
      else if (w_start && w_step_edge)
        r_step_mode <= 1'b1;
    end
  end
`else
  logic w_unused_step;

  assign w_unused_step = io_seq.step;
  assign w_step_edge   = 1'b0;
  assign w_step_mode   = 1'b0;
`endif

  // edges only matter in IDLE; anything seen while busy is dropped, not queued
  assign w_start = (r_state == ST_IDLE) && (w_run_edge || w_step_edge) && !io_seq.halt;

  // DONE in the STB cycle itself must still end this phase, hence the live input term
  assign w_end = (r_state == ST_EXEC) && r_stb &&
                 (r_done || io_seq.done || (r_phase == LP_LAST_PHASE));

  // HALT in the final STB cycle still counts as pending
  assign w_stop = r_halt_pend || io_seq.halt || w_step_mode;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_stb_nxt   = r_stb;
    if (r_state == ST_IDLE) begin
      w_stb_nxt   = 1'b0;
      w_phase_nxt = 4'd0;
      if (w_start)
        w_state_nxt = ST_FETCH;
    end else if (!r_stb) begin
      w_stb_nxt = 1'b1;
    end else begin
      w_stb_nxt = 1'b0;
      case (r_state)
        ST_FETCH: begin
          case (io_seq.seqtype)
            2'b11:   w_state_nxt = ST_AUTO1;
            2'b01:   w_state_nxt = ST_IND;
            default: begin
              w_state_nxt = ST_EXEC;
              w_phase_nxt = 4'd1;
            end
          endcase
        end
        ST_AUTO1: w_state_nxt = ST_AUTO2;
        ST_AUTO2, ST_IND: begin
          w_state_nxt = ST_EXEC;
          w_phase_nxt = 4'd1;
        end
        ST_EXEC: begin
          if (w_end) begin
            w_state_nxt = w_stop ? ST_IDLE : ST_FETCH;
            w_phase_nxt = 4'd0;
          end else begin
            w_phase_nxt = r_phase + 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = 4'd0;
        end
      endcase
    end
  end

  // the edge register loads the live RUN level during reset so a level held
  // through reset is not mistaken for a fresh edge afterwards
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= 4'd0;
      r_stb       <= 1'b0;
      r_run_q     <= io_seq.run;
      r_done      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_instr_end <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_stb       <= w_stb_nxt;
      r_run_q     <= io_seq.run;
      r_instr_end <= w_end;

      // done flag lives only for the CK->STB span of one execute phase
      if ((r_state == ST_EXEC) && !r_stb)
        r_done <= r_done | io_seq.done;
      else
        r_done <= 1'b0;

      if (w_state_nxt == ST_IDLE)
        r_halt_pend <= 1'b0;
      else if (io_seq.halt)
        r_halt_pend <= 1'b1;
    end
  end

  // Moore decode of the registered state
  assign io_seq.ck_fetch  = (r_state == ST_FETCH) && !r_stb;
  assign io_seq.stb_fetch = (r_state == ST_FETCH) &&  r_stb;
  assign io_seq.ck_auto1  = (r_state == ST_AUTO1) && !r_stb;
  assign io_seq.stb_auto1 = (r_state == ST_AUTO1) &&  r_stb;
  assign io_seq.ck_auto2  = (r_state == ST_AUTO2) && !r_stb;
  assign io_seq.stb_auto2 = (r_state == ST_AUTO2) &&  r_stb;
  assign io_seq.ck_ind    = (r_state == ST_IND)   && !r_stb;
  assign io_seq.stb_ind   = (r_state == ST_IND)   &&  r_stb;
  assign io_seq.running   = (r_state != ST_IDLE);
  assign io_seq.phase     = (r_state == ST_EXEC) ? r_phase : 4'd0;
  assign io_seq.instr_end = r_instr_end;

  always_comb begin
    io_seq.ck  = '0;
    io_seq.stb = '0;
    for (int k = 0; k < NPHASE; k++) begin
      if ((r_state == ST_EXEC) && (r_phase == 4'(k + 1))) begin
        io_seq.ck[k]  = !r_stb;
        io_seq.stb[k] =  r_stb;
      end
    end
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter NPHASE, 6, number of execution phases per instruction; legal range 1..15.
REQ-002 CLK  in  1  system clock; all state changes on rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 RUN  in  1  start continuous execution on rising edge.
REQ-005 HALT  in  1  level; stop at the next instruction boundary.
REQ-006 STEP  in  1  execute exactly one instruction on rising edge.
REQ-007 DONE  in  1  early end of execute phases, from the instruction handlers.
REQ-008 SEQTYPE  in  2  {ppind,ind}, addressing class of the fetched instruction.
REQ-009 CK_FETCH, STB_FETCH, CK_AUTO1, STB_AUTO1, CK_AUTO2, STB_AUTO2, CK_IND, STB_IND  out  1 each  fetch/auto-index/indirect phase pulses.
REQ-010 CK  out  NPHASE  execute-phase setup pulses; bit k belongs to phase k+1.
REQ-011 STB  out  NPHASE  execute-phase strobe pulses; bit k belongs to phase k+1.
REQ-012 RUNNING  out  1  high while any phase is active.
REQ-013 PHASE  out  4  current execute phase number 1..NPHASE; 0 outside execute phases.
REQ-014 INSTR_END  out  1  one-cycle pulse in the first cycle after an instruction ends.

Function
REQ-015 States: IDLE, FETCH, AUTO1, AUTO2, IND, EXEC(1..NPHASE); every non-IDLE state SHALL last exactly 2 cycles: CK cycle, then STB cycle.
REQ-016 Outputs SHALL be Moore-decoded from the registered state; exactly one CK*/STB* output high per non-IDLE cycle, none in IDLE.
REQ-017 RUN and STEP edges SHALL be detected as input & ~input_q; an edge seen in IDLE at cycle t SHALL put CK_FETCH high at t+1.
REQ-018 Edges outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-019 Simultaneous RUN and STEP edges SHALL start single-step mode.
REQ-020 A RUN or STEP edge in IDLE while HALT is high SHALL be ignored.
REQ-021 SEQTYPE SHALL be sampled in the STB_FETCH cycle.
REQ-022 SEQTYPE routing: 2'b11 -> AUTO1 -> AUTO2 -> EXEC1; 2'b01 -> IND -> EXEC1; 2'b00 and 2'b10 -> EXEC1.
REQ-023 DONE high in either cycle of EXEC(k) SHALL set a done flag; the flag SHALL end the instruction after STB of that phase.
REQ-024 The done flag SHALL clear on leaving the phase.
REQ-025 DONE outside EXEC states SHALL be ignored.
REQ-026 Without DONE, the instruction SHALL end after STB of EXEC(NPHASE).
REQ-027 HALT high in any cycle SHALL set halt_pending; at instruction end with halt_pending or single-step mode, next state SHALL be IDLE, else FETCH.
REQ-028 halt_pending and single-step mode SHALL clear on entering IDLE.
REQ-029 HALT SHALL never truncate an instruction in progress.
REQ-030 INSTR_END SHALL pulse in the cycle after the final STB, coinciding with CK_FETCH or with the first IDLE cycle.
REQ-031 RUNNING SHALL be low in IDLE and high in all other states.

Reset
REQ-032 RESET SHALL asynchronously force IDLE and clear halt_pending, the done flag, single-step mode and all outputs to 0, including mid-phase.
REQ-033 RESET SHALL load the edge registers with the current RUN/STEP levels, so a level held through reset does not start execution.

Configuration
REQ-034 With macro SEQ_SINGLE_STEP_EN defined, STEP SHALL behave per REQ-006/017/019/027.
REQ-035 With SEQ_SINGLE_STEP_EN undefined, the STEP port SHALL remain present but be ignored and single-step logic SHALL be absent.

Verification (NPHASE=6, RUN edge sampled at cycle 0)
REQ-036 SEQTYPE=00, DONE low -> CK_FETCH c1, STB_FETCH c2, CK[0] c3, STB[5] c14, INSTR_END+CK_FETCH c15.
REQ-037 DONE pulse at c5 (CK[1]) -> STB[1] c6, CK_FETCH c7, CK[2] never asserted, PHASE=2 in c5-c6.
REQ-038 SEQTYPE=11 -> AUTO1 c3-c4, AUTO2 c5-c6, CK[0] c7; SEQTYPE=01 -> CK_IND c3, CK[0] c5.
REQ-039 HALT one-cycle pulse at c4 -> instruction completes to STB[5] c14; c15 IDLE, RUNNING=0, INSTR_END=1, no CK_FETCH; a new RUN edge restarts.
REQ-040 SEQ_SINGLE_STEP_EN defined: STEP edge -> one full instruction, then IDLE. Undefined: STEP edge -> RUNNING stays 0.
REQ-041 RESET at c8 (within EXEC3) with RUN held high -> all outputs 0 in c8; no FETCH until RUN falls and rises again.
